rain_catch_engine: RTL and testbench



---
 rtl/rain_catch_engine.sv | 198 +++++++++++++++++++
 tb/tb_rain_catch_engine.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rain_catch_engine.sv
// rain_catch_engine: strobe-driven rain-catching game core.
// Tracks NUM_DROPS falling drops (per-drop fall period 1..4 frame ticks),
// a button-steered bucket, catch detection, a saturating fill level and a
// saturating score, and renders an RGB565 pixel for the scan coordinate.
// Ports:
//   clk12p5mhz_clk, reset         clock, synchronous active-high reset
//   frame_tick, move_tick         one-cycle game / bucket strobes
//   pause_switch                  freezes drops and bucket
//   left_pb, right_pb, down_pb    debounced buttons (down_pb empties bucket)
//   coordinate_x/y                scan position
//   rain_color                    registered pixel, 1-cycle latency
//   bucket_fill, score, full      game status

// Single drop channel: divider, position, catch test and pixel hit test.
module rain_drop #(
  parameter int IDX       = 0,
  parameter int SCREEN_W  = 96,
  parameter int SCREEN_H  = 64,
  parameter int NUM_DROPS = 12,
  parameter int BUCKET_W  = 18,
  parameter int DROP_LEN  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_adv,
  input  logic [7:0] i_spawn_x,
  input  logic [7:0] i_bucket_x,
  input  logic [7:0] i_cx,
  input  logic [6:0] i_cy,
  output logic       o_caught,
  output logic       o_hit
);
  localparam logic [1:0] PM1     = 2'(IDX % 4);
  localparam logic [6:0] CATCH_Y = 7'(SCREEN_H - 8);
  localparam logic [7:0] X0      = 8'(IDX * (SCREEN_W / NUM_DROPS) + 2);
  localparam logic [8:0] IN_HI   = 9'(BUCKET_W - 4);

  logic [1:0] r_div;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic       w_step, w_res;
  logic [8:0] w_x9, w_bx9;
  logic [7:0] w_y8, w_cy8;

  assign w_x9  = {1'b0, r_x};
  assign w_bx9 = {1'b0, i_bucket_x};
  assign w_y8  = {1'b0, r_y};
  assign w_cy8 = {1'b0, i_cy};

  assign w_step   = i_adv && (r_div == PM1);
  // A step taken at the catch row resolves (catch or miss) instead of moving.
  assign w_res    = w_step && (r_y == CATCH_Y);
  assign o_caught = w_res && (w_bx9 + 9'd3 <= w_x9) && (w_x9 + 9'd1 <= w_bx9 + IN_HI);
  assign o_hit    = ((i_cx == r_x) || ({1'b0, i_cx} == w_x9 + 9'd1)) &&
                    (w_cy8 >= w_y8) && (w_cy8 <= w_y8 + 8'(DROP_LEN - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
      r_x   <= X0;
      r_y   <= '0;
    end else if (i_adv) begin
      if (r_div == PM1) begin
        r_div <= '0;
        if (w_res) begin
          r_y <= '0;
          r_x <= i_spawn_x;
        end else begin
          r_y <= r_y + 7'd1;
        end
      end else begin
        r_div <= r_div + 2'd1;
      end
    end
  end
endmodule

module rain_catch_engine #(
  parameter int NUM_DROPS = 12,
  parameter int SCREEN_W  = 96,
  parameter int SCREEN_H  = 64,
  parameter int BUCKET_W  = 18,
  parameter int DROP_LEN  = 3,
  parameter int FILL_MAX  = 5,
  // Derived; not meant to be overridden.
  parameter int FILL_W    = $clog2(FILL_MAX + 1)
) (
  input  logic              clk12p5mhz_clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              move_tick,
  input  logic              pause_switch,
  input  logic              left_pb,
  input  logic              right_pb,
  input  logic              down_pb,
  input  logic [7:0]        coordinate_x,
  input  logic [6:0]        coordinate_y,
  output logic [15:0]       rain_color,
  output logic [FILL_W-1:0] bucket_fill,
  output logic [7:0]        score,
  output logic              full
);
  localparam int              CW    = $clog2(NUM_DROPS + 1);
  localparam logic [FILL_W-1:0] FMAX = FILL_W'(FILL_MAX);
  localparam logic [7:0]      BX0   = 8'((SCREEN_W - BUCKET_W) / 2);
  localparam logic [7:0]      BXMAX = 8'(SCREEN_W - BUCKET_W);

  logic [15:0]          r_lfsr;
  logic [7:0]           r_bx;
  logic [FILL_W-1:0]    r_fill;
  logic [7:0]           r_score;
  logic [15:0]          r_color;

  logic                 w_adv, w_mv, w_fb;
  logic [7:0]           w_l8, w_spawn;
  logic [NUM_DROPS-1:0] w_caught, w_hit;
  logic [CW-1:0]        w_n;
  logic [8:0]           w_fsum, w_ssum;
  logic [FILL_W-1:0]    w_fill_nx;
  logic [7:0]           w_score_nx;
  logic [8:0]           w_cx9, w_cy9, w_bx9;
  logic                 w_in, w_wall, w_bottom, w_fillpx;
  logic [15:0]          w_color;

  assign w_adv = frame_tick && !pause_switch;
  assign w_mv  = move_tick && !pause_switch;
  assign w_fb  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // Fold out-of-range LFSR columns back onto the screen.
  assign w_l8    = {1'b0, r_lfsr[6:0]};
  assign w_spawn = (w_l8 >= 8'(SCREEN_W - 1)) ? w_l8 - 8'(SCREEN_W / 2) : w_l8;

  for (genvar g = 0; g < NUM_DROPS; g++) begin : g_drop
    rain_drop #(
      .IDX(g), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
      .NUM_DROPS(NUM_DROPS), .BUCKET_W(BUCKET_W), .DROP_LEN(DROP_LEN)
    ) u_drop (
      .clk(clk12p5mhz_clk), .reset(reset), .i_adv(w_adv),
      .i_spawn_x(w_spawn), .i_bucket_x(r_bx),
      .i_cx(coordinate_x), .i_cy(coordinate_y),
      .o_caught(w_caught[g]), .o_hit(w_hit[g])
    );
  end

  always_comb begin
    w_n = '0;
    for (int i = 0; i < NUM_DROPS; i++) w_n = w_n + CW'(w_caught[i]);
  end

  assign w_fsum     = 9'(r_fill) + 9'(w_n);
  assign w_fill_nx  = (w_fsum >= 9'(FILL_MAX)) ? FMAX : w_fsum[FILL_W-1:0];
  assign w_ssum     = 9'(r_score) + 9'(w_n);
  assign w_score_nx = w_ssum[8] ? 8'hFF : w_ssum[7:0];

  // Render from the current game state.
  assign w_cx9    = {1'b0, coordinate_x};
  assign w_cy9    = {2'b0, coordinate_y};
  assign w_bx9    = {1'b0, r_bx};
  assign w_in     = (w_cx9 >= w_bx9 + 9'd3) && (w_cx9 <= w_bx9 + 9'(BUCKET_W - 4));
  assign w_wall   = (w_cy9 >= 9'(SCREEN_H - 8)) && (w_cy9 <= 9'(SCREEN_H - 1)) &&
                    (((w_cx9 >= w_bx9) && (w_cx9 <= w_bx9 + 9'd2)) ||
                     ((w_cx9 >= w_bx9 + 9'(BUCKET_W - 3)) && (w_cx9 <= w_bx9 + 9'(BUCKET_W - 1))));
  assign w_bottom = (w_cy9 >= 9'(SCREEN_H - 3)) && (w_cy9 <= 9'(SCREEN_H - 1)) && w_in;
  // cy >= H-3-fill rewritten as cy+fill >= H-3 to stay unsigned.
  assign w_fillpx = (r_fill != '0) && (w_cy9 + 9'(r_fill) >= 9'(SCREEN_H - 3)) &&
                    (w_cy9 <= 9'(SCREEN_H - 4)) && w_in;

  always_comb begin
    w_color = 16'h0000;
    if (w_wall || w_bottom)        w_color = 16'hF800;
    else if ((|w_hit) || w_fillpx) w_color = 16'hAEDF;
  end

  always_ff @(posedge clk12p5mhz_clk) begin
    if (reset) begin
      r_lfsr  <= 16'hACE1;
      r_bx    <= BX0;
      r_fill  <= '0;
      r_score <= '0;
      r_color <= '0;
    end else begin
      r_lfsr  <= {w_fb, r_lfsr[15:1]};
      r_color <= w_color;
      if (w_adv) r_score <= w_score_nx;
      if (down_pb)    r_fill <= '0;
      else if (w_adv) r_fill <= w_fill_nx;
      if (w_mv) begin
        if (left_pb && !right_pb && (r_bx >= 8'd1))         r_bx <= r_bx - 8'd1;
        else if (right_pb && !left_pb && (r_bx <= BXMAX - 8'd1)) r_bx <= r_bx + 8'd1;
      end
    end
  end

  assign rain_color  = r_color;
  assign bucket_fill = r_fill;
  assign score       = r_score;
  assign full        = (r_fill == FMAX);
endmodule

// File: tb/tb_rain_catch_engine.sv
module tb_rain_catch_engine;
  localparam int ND = 12, W = 96, H = 64, BW = 18, DL = 3, FM = 5, FW = 3;
  localparam int CY = H - 8;
  localparam logic [15:0] RED = 16'hF800, BLUE = 16'hAEDF;

  logic clk = 0;
  logic reset, frame_tick, move_tick, pause_switch, left_pb, right_pb, down_pb;
  logic [7:0] coordinate_x;
  logic [6:0] coordinate_y;
  logic [15:0] rain_color;
  logic [FW-1:0] bucket_fill;
  logic [7:0] score;
  logic full;

  always #5 clk = ~clk;

  rain_catch_engine dut (
    .clk12p5mhz_clk(clk), .reset(reset), .frame_tick(frame_tick), .move_tick(move_tick),
    .pause_switch(pause_switch), .left_pb(left_pb), .right_pb(right_pb), .down_pb(down_pb),
    .coordinate_x(coordinate_x), .coordinate_y(coordinate_y), .rain_color(rain_color),
    .bucket_fill(bucket_fill), .score(score), .full(full)
  );

  int tests = 0, fails = 0;

  // Reference model: game state in plain integers.
  int m_x[ND], m_y[ND], m_div[ND];
  int m_bx, m_fill, m_score;
  int m_lfsr;
  logic [15:0] e_col;

  function automatic void m_reset();
    for (int i = 0; i < ND; i++) begin
      m_x[i] = i * (W / ND) + 2; m_y[i] = 0; m_div[i] = 0;
    end
    m_bx = (W - BW) / 2; m_fill = 0; m_score = 0; m_lfsr = 'hACE1;
  endfunction

  function automatic logic [15:0] m_render(int cx, int cy);
    int bx = m_bx;
    if (cy >= H - 8 && cy <= H - 1 &&
        ((cx >= bx && cx <= bx + 2) || (cx >= bx + BW - 3 && cx <= bx + BW - 1))) return RED;
    if (cy >= H - 3 && cy <= H - 1 && cx >= bx + 3 && cx <= bx + BW - 4) return RED;
    for (int i = 0; i < ND; i++)
      if ((cx == m_x[i] || cx == m_x[i] + 1) && cy >= m_y[i] && cy <= m_y[i] + DL - 1) return BLUE;
    if (m_fill > 0 && cy >= H - 3 - m_fill && cy <= H - 4 && cx >= bx + 3 && cx <= bx + BW - 4)
      return BLUE;
    return 16'h0;
  endfunction

  function automatic void m_update(bit ft, bit mt, bit ps, bit lp, bit rp, bit dp);
    int n = 0;
    int l = m_lfsr % 128;
    int sp = (l >= W - 1) ? l - W / 2 : l;
    int bit0;
    if (ft && !ps) begin
      for (int i = 0; i < ND; i++) begin
        if (m_div[i] == i % 4) begin
          m_div[i] = 0;
          if (m_y[i] == CY) begin
            if (m_bx + 3 <= m_x[i] && m_x[i] + 1 <= m_bx + BW - 4) n++;
            m_y[i] = 0; m_x[i] = sp;
          end else m_y[i]++;
        end else m_div[i]++;
      end
      m_score = (m_score + n > 255) ? 255 : m_score + n;
    end
    if (dp) m_fill = 0;
    else if (ft && !ps) m_fill = (m_fill + n > FM) ? FM : m_fill + n;
    if (mt && !ps) begin
      if (lp && !rp && m_bx >= 1) m_bx--;
      else if (rp && !lp && m_bx <= W - BW - 1) m_bx++;
    end
    bit0 = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
    m_lfsr = (m_lfsr >> 1) | (bit0 << 15);
  endfunction

  // One clock: drive inputs, advance model, wait edge, land 1 time unit after it.
  task automatic cyc(input bit rst, input bit ft, input bit mt, input bit ps,
                     input bit lp, input bit rp, input bit dp, input int cx, input int cy);
    reset = rst; frame_tick = ft; move_tick = mt; pause_switch = ps;
    left_pb = lp; right_pb = rp; down_pb = dp;
    coordinate_x = 8'(cx); coordinate_y = 7'(cy);
    if (rst) begin e_col = 16'h0; m_reset(); end
    else begin e_col = m_render(cx, cy); m_update(ft, mt, ps, lp, rp, dp); end
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a coordinate with no strobes and check the pixel one cycle later.
  task automatic pix(input string name, input int cx, input int cy, input logic [15:0] exp);
    cyc(0, 0, 0, 0, 0, 0, 0, cx, cy);
    chk(name, rain_color, exp);
  endtask

  typedef struct { int cx; int cy; logic [15:0] col; } vec_t;
  vec_t tbl[16];

  initial begin
    int k, tgt, sx;
    bit lp, rp;
    tbl[0]  = '{39, 60, RED};  tbl[1]  = '{45, 62, RED};  tbl[2]  = '{45, 59, 16'h0};
    tbl[3]  = '{2, 0, BLUE};   tbl[4]  = '{3, 2, BLUE};   tbl[5]  = '{3, 3, 16'h0};
    tbl[6]  = '{4, 0, 16'h0};  tbl[7]  = '{10, 1, BLUE};  tbl[8]  = '{56, 56, RED};
    tbl[9]  = '{57, 56, 16'h0}; tbl[10] = '{42, 61, RED}; tbl[11] = '{53, 63, RED};
    tbl[12] = '{38, 63, 16'h0}; tbl[13] = '{95, 63, 16'h0}; tbl[14] = '{91, 0, BLUE};
    tbl[15] = '{92, 0, 16'h0};

    // Reset with strobes asserted: they must be ignored.
    cyc(1, 1, 1, 0, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 1, 0, 0, 0, 0);
    chk("reset_color", rain_color, 0);
    chk("reset_score", score, 0);
    chk("reset_fill", bucket_fill, 0);
    chk("reset_full", full, 0);

    // Render at reset state: bucket_x=39, fill=0, drop i at (8i+2, 0).
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, tbl[i].cx, tbl[i].cy);
      chk($sformatf("tbl_render[%0d]", i), rain_color, tbl[i].col);
    end

    // Drop fall: 56 frame ticks.
    for (int i = 0; i < 56; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    pix("drop0_y56", 2, 56, BLUE);
    pix("drop0_above", 2, 55, 16'h0);
    pix("drop1_y28", 10, 28, BLUE);
    pix("drop1_above", 10, 27, 16'h0);
    pix("drop1_below", 10, 31, 16'h0);
    chk("fall_score", score, 0);
    // Tick 57: drops 0/4/8 resolve as misses and respawn at the top.
    sx = ((m_lfsr % 128) >= W - 1) ? (m_lfsr % 128) - W / 2 : (m_lfsr % 128);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("miss_score", score, 0);
    chk("miss_fill", bucket_fill, 0);
    pix("respawn_top", sx, 0, BLUE);

    // Bucket bounds.
    for (int i = 0; i < 50; i++) cyc(0, 0, 1, 0, 1, 0, 0, 0, 0);
    pix("left_edge", 0, 63, RED);
    pix("left_past", 18, 63, 16'h0);
    for (int i = 0; i < 100; i++) cyc(0, 0, 1, 0, 0, 1, 0, 0, 0);
    pix("right_edge", 95, 63, RED);
    pix("right_lo", 78, 63, RED);
    pix("right_past", 77, 63, 16'h0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 1, 1, 0, 0, 0);
    pix("both_hold", 77, 63, 16'h0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 1, 1, 0, 0, 0, 0);
    pix("pause_hold", 77, 63, 16'h0);
    pix("pause_hold2", 78, 63, RED);

    // Randomized play against the model, bucket steered under the lowest drop.
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        cyc(1, 1, 1, 0, 0, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 1, 0, 0, 0);
        chk("midreset_score", score, 0);
        chk("midreset_fill", bucket_fill, 0);
        chk("midreset_full", full, 0);
        pix("midreset_bucket", 39, 63, RED);
      end
      k = 0;
      for (int i = 1; i < ND; i++) if (m_y[i] > m_y[k]) k = i;
      tgt = m_x[k] - 8;
      if (tgt < 0) tgt = 0;
      if (tgt > W - BW) tgt = W - BW;
      lp = m_bx > tgt; rp = m_bx < tgt;
      if ($urandom_range(0, 7) == 0) begin lp = $urandom_range(0, 1); rp = $urandom_range(0, 1); end
      cyc(0, $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
          lp, rp, $urandom_range(0, 63) == 0, $urandom_range(0, 100),
          $urandom_range(0, 1) ? $urandom_range(50, 70) : $urandom_range(0, 63));
      chk("rnd_color", rain_color, e_col);
      chk("rnd_score", score, m_score);
      chk("rnd_fill", bucket_fill, m_fill);
      chk("rnd_full", full, m_fill == FM);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
